// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder: converts the stochastic adder's output bitstream back to binary.
// Counts 1s over a programmable window of enabled samples. Each result is the raw
// count plus the count rescaled by the adder's 1/INUM factor (<< LOGINUM).
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   start, win_len request a window of win_len enabled samples (clamped to 2^WIDTH)
//   in_en, in_bit  bitstream sample and its qualifier
//   busy           window in progress
//   out_valid      result offered, out_ready accepts it
//   out_cnt        number of 1s in the window
//   out_sum        out_cnt << LOGINUM
module sc_stream_decoder #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LOGINUM = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [WIDTH:0]             win_len,
  input  logic                       in_en,
  input  logic                       in_bit,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH:0]             out_cnt,
  output logic [WIDTH+LOGINUM:0]     out_sum
);

  localparam int unsigned CW = WIDTH + 1;
  localparam int unsigned SW = WIDTH + LOGINUM + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [CW-1:0]   rem, rem_nxt;
  logic [CW-1:0]   out_cnt_nxt;
  logic [SW-1:0]   out_sum_nxt;
  logic            busy_nxt, valid_nxt;

  logic [CW-1:0]   max_len;
  logic [CW-1:0]   len_clamped;
  logic [CW-1:0]   cnt_plus;
  logic [CW-1:0]   first_cnt;
  logic            accept;
  logic            load;

  // Window length clamp and the acceptance cycle's first sample
  always_comb begin
    max_len     = CW'(1) << WIDTH;
    len_clamped = (win_len > max_len) ? max_len : win_len;
    accept      = start && (win_len != '0);
    cnt_plus    = cnt + CW'(in_bit);
    first_cnt   = CW'(in_en & in_bit);
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rem_nxt     = rem;
    out_cnt_nxt = out_cnt;
    load        = 1'b0;

    case (state)
      IDLE: begin
        if (accept) load = 1'b1;
      end
      RUN: begin
        if (in_en) begin
          if (rem == CW'(1)) begin
            state_nxt   = DONE;
            out_cnt_nxt = cnt_plus;
            rem_nxt     = '0;
          end else begin
            cnt_nxt = cnt_plus;
            rem_nxt = rem - CW'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          if (accept) load = 1'b1;
          else        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Accepting a window: the acceptance cycle itself is sample 1 when in_en=1
    if (load) begin
      if (in_en && (len_clamped == CW'(1))) begin
        state_nxt   = DONE;
        out_cnt_nxt = first_cnt;
        cnt_nxt     = '0;
        rem_nxt     = '0;
      end else begin
        state_nxt = RUN;
        cnt_nxt   = first_cnt;
        rem_nxt   = len_clamped - CW'(in_en);
      end
    end

    out_sum_nxt = SW'(out_cnt_nxt) << LOGINUM;
    busy_nxt    = (state_nxt == RUN);
    valid_nxt   = (state_nxt == DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rem       <= '0;
      out_cnt   <= '0;
      out_sum   <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rem       <= rem_nxt;
      out_cnt   <= out_cnt_nxt;
      out_sum   <= out_sum_nxt;
      busy      <= busy_nxt;
      out_valid <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Self-checking bench for sc_stream_decoder (WIDTH=8, LOGINUM=2).
module tb_sc_stream_decoder;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned LOGINUM = 2;
  localparam int unsigned CW      = WIDTH + 1;
  localparam int unsigned SW      = WIDTH + LOGINUM + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] win_len;
  logic          in_en;
  logic          in_bit;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_cnt;
  logic [SW-1:0] out_sum;

  int tests  = 0;
  int failed = 0;
  int exp_q[$];

  typedef struct {
    int wl;       // requested window length
    int bm;       // bit pattern: 0 all zero, 1 all one, 2 alternating from 1
    int em;       // enable pattern: 0 always on, 1 toggling from 1
    int exp_cnt;
    int exp_lat;  // edges from acceptance edge (=1) to out_valid visible
  } vec_t;

  vec_t vecs[7];

  sc_stream_decoder #(.WIDTH(WIDTH), .LOGINUM(LOGINUM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .win_len   (win_len),
    .in_en     (in_en),
    .in_bit    (in_bit),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cnt   (out_cnt),
    .out_sum   (out_sum)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic bitf(input int bm, input int s);
    if (bm == 0) return 1'b0;
    if (bm == 1) return 1'b1;
    return (s % 2 == 0);
  endfunction

  // Pop the scoreboard and compare the offered result
  task automatic check_result(input string name);
    int e;
    if (exp_q.size() == 0) begin
      tests++;
      failed++;
      $display("FAIL %s_sb: got result %0d expected none queued", name, out_cnt);
    end else begin
      e = exp_q.pop_front();
      check({name, "_cnt"}, int'(out_cnt), e);
      check({name, "_sum"}, int'(out_sum), e << LOGINUM);
    end
  endtask

  task automatic run_window(input int wl, input int bm, input int em, input int ec,
                            input int el, input bit mid_start, input bit do_ack);
    int c, s, lat;
    bit en;
    exp_q.push_back(ec);
    c = 0; s = 0; lat = 0;
    start = 1'b1;
    win_len = CW'(wl);
    while (lat == 0 && c < 2000) begin
      en = (em == 0) || (c % 2 == 0);
      in_en  = en;
      in_bit = en ? bitf(bm, s) : 1'b1;
      if (c > 0) start = (mid_start && c == 2);
      if (mid_start && c == 2) win_len = CW'(2);
      step();
      if (en) s++;
      c++;
      if (c == 1 && el > 1) check("busy_run", int'(busy), 1);
      if (out_valid) lat = c;
    end
    start = 1'b0; in_en = 1'b0; in_bit = 1'b0;
    check("latency", lat, el);
    check("busy_done", int'(busy), 0);
    check_result("win");
    if (do_ack) begin
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("valid_after_ack", int'(out_valid), 0);
      check("cnt_hold", int'(out_cnt), ec);
    end
  endtask

  initial begin
    vecs[0] = '{16,  1, 0, 16,  16};
    vecs[1] = '{256, 2, 0, 128, 256};
    vecs[2] = '{300, 2, 0, 128, 256};
    vecs[3] = '{8,   1, 1, 8,   15};
    vecs[4] = '{1,   1, 0, 1,   1};
    vecs[5] = '{5,   0, 0, 0,   5};
    vecs[6] = '{3,   2, 1, 2,   5};

    rst_n = 1'b0; start = 1'b0; win_len = '0; in_en = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    check("rst_busy",  int'(busy), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_cnt",   int'(out_cnt), 0);
    check("rst_sum",   int'(out_sum), 0);
    step();

    for (int i = 0; i < 7; i++)
      run_window(vecs[i].wl, vecs[i].bm, vecs[i].em, vecs[i].exp_cnt, vecs[i].exp_lat, 1'b0, 1'b1);

    // Backpressure: start pulsed in RUN and in DONE without ready is ignored
    run_window(6, 1, 0, 6, 6, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      start = (k == 2);
      win_len = CW'(3);
      in_en = 1'b1; in_bit = 1'b1;
      step();
      check("bp_valid", int'(out_valid), 1);
      check("bp_busy",  int'(busy), 0);
      check("bp_cnt",   int'(out_cnt), 6);
    end
    start = 1'b0;

    // Back-to-back: handshake and new start in the same cycle
    exp_q.push_back(4);
    out_ready = 1'b1; start = 1'b1; win_len = CW'(4); in_en = 1'b1; in_bit = 1'b1;
    step();
    out_ready = 1'b0; start = 1'b0;
    check("b2b_busy",  int'(busy), 1);
    check("b2b_valid", int'(out_valid), 0);
    check("b2b_hold",  int'(out_cnt), 6);
    for (int k = 0; k < 3; k++) begin
      step();
      check("b2b_valid_seq", int'(out_valid), (k == 2) ? 1 : 0);
    end
    in_en = 1'b0;
    check_result("b2b");
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("b2b_ack", int'(out_valid), 0);

    // Reset mid-RUN after 10 samples
    start = 1'b1; win_len = CW'(16); in_en = 1'b1; in_bit = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 9; k++) step();
    check("mid_busy", int'(busy), 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; in_en = 1'b0;
    check("mrst_busy",  int'(busy), 0);
    check("mrst_valid", int'(out_valid), 0);
    check("mrst_cnt",   int'(out_cnt), 0);
    check("mrst_sum",   int'(out_sum), 0);

    // Zero-length start is ignored
    start = 1'b1; win_len = '0; in_en = 1'b1; in_bit = 1'b1;
    step();
    start = 1'b0;
    check("zero_busy",  int'(busy), 0);
    check("zero_valid", int'(out_valid), 0);
    step();
    check("zero_busy2", int'(busy), 0);

    run_window(4, 0, 0, 0, 4, 1'b0, 1'b1);

    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
